// File: rtl/program_loader.sv
// program_loader: receives a framed program image from the UART receiver
// and writes big-endian 16-bit words into the code RAM.
module program_loader #(
  parameter int ADDRESS_WIDTH  = 10,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 12000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [15:0]              mem_data_out,
  output logic                     mem_write_enable,
  output logic                     cpu_halt,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int IW = ADDRESS_WIDTH + 1;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]   MAX_CNT = 16'(MAX_WORDS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_COUNT_HI,
    S_COUNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHECKSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state, state_n;

  logic [7:0]    cnt_hi;
  logic [7:0]    hi_byte;
  logic [7:0]    sum;
  logic [7:0]    buf_data;
  logic          buf_valid;
  logic [IW-1:0] index;
  logic [IW-1:0] count;
  logic [TW-1:0] timer;

  logic [7:0]    byte_in;
  logic          byte_avail;
  logic          load;
  logic          take;
  logic          timeout;
  logic [15:0]   count_in;
  logic [IW-1:0] index_inc;

  // a byte held over from a WRITE cycle takes priority over the live strobe
  assign byte_avail = buf_valid | rx_valid;
  assign byte_in    = buf_valid ? buf_data : rx_data;
  assign count_in   = {cnt_hi, byte_in};
  assign index_inc  = index + IW'(1);

  assign busy = (state != S_IDLE) && (state != S_DONE) &&
                (state != S_ERROR);
  assign cpu_halt         = busy;
  assign done             = (state == S_DONE);
  assign error            = (state == S_ERROR);
  assign mem_write_enable = (state == S_WRITE);

  assign load    = start & ~busy;
  assign take    = byte_avail & busy & (state != S_WRITE);
  assign timeout = busy & ~rx_valid & (timer == T_LAST);

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // next-state decode; a timeout overrides any byte-driven move
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (start) state_n = S_COUNT_HI;
      S_COUNT_HI:
        if (take) state_n = S_COUNT_LO;
      S_COUNT_LO:
        if (take) begin
          if (count_in == 16'd0)       state_n = S_CHECKSUM;
          else if (count_in > MAX_CNT) state_n = S_ERROR;
          else                         state_n = S_DATA_HI;
        end
      S_DATA_HI:
        if (take) state_n = S_DATA_LO;
      S_DATA_LO:
        if (take) state_n = S_WRITE;
      S_WRITE:
        state_n = (index_inc == count) ? S_CHECKSUM : S_DATA_HI;
      S_CHECKSUM:
        if (take) state_n = (byte_in == sum) ? S_DONE : S_ERROR;
      default:
        state_n = S_IDLE;
    endcase
    if (timeout) state_n = S_ERROR;
  end

  // datapath: byte buffer, idle timer, word assembly, checksum, index
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_hi       <= '0;
      hi_byte      <= '0;
      sum          <= '0;
      buf_data     <= '0;
      buf_valid    <= 1'b0;
      index        <= '0;
      count        <= '0;
      timer        <= '0;
      mem_address  <= '0;
      mem_data_out <= '0;
    end else if (load) begin
      index     <= '0;
      sum       <= '0;
      timer     <= '0;
      buf_valid <= 1'b0;
    end else if (busy) begin
      if (rx_valid)             timer <= '0;
      else if (timer != T_LAST) timer <= timer + TW'(1);

      if (state == S_WRITE) begin
        index <= index_inc;
        if (rx_valid) begin
          buf_valid <= 1'b1;
          buf_data  <= rx_data;
        end
      end else if (buf_valid) begin
        buf_valid <= rx_valid;
        if (rx_valid) buf_data <= rx_data;
      end

      if (take) begin
        unique case (1'b1)
          (state == S_COUNT_HI): cnt_hi <= byte_in;
          (state == S_COUNT_LO): count  <= IW'(count_in);
          (state == S_DATA_HI): begin
            hi_byte <= byte_in;
            sum     <= sum + byte_in;
          end
          (state == S_DATA_LO): begin
            mem_data_out <= {hi_byte, byte_in};
            mem_address  <= index[ADDRESS_WIDTH-1:0];
            sum          <= sum + byte_in;
          end
          default: ;
        endcase
      end
    end else begin
      buf_valid <= 1'b0;
    end
  end

endmodule
